// File: rtl/music_addr_seek_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_addr_seek_pkg
// Purpose  : Shared FSM/direction encodings and seek-step constants for the
//            music_addr_seek playback address block.
// Revision : 1.0
// ============================================================================
package music_addr_seek_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_HELD_FS = 3'd1,
        ST_HELD_BS = 3'd2,
        ST_HELD_FL = 3'd3,
        ST_HELD_BL = 3'd4,
        ST_APPLY   = 3'd5
    } seek_state_t;

    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } seek_dir_t;

    localparam int unsigned DEF_ADDRS_PER_SEC = 3000;
    localparam int unsigned DEF_SHORT_SEC     = 10;
    localparam int unsigned DEF_LONG_SEC      = 30;

    function automatic int unsigned step_of(input int unsigned sec, input int unsigned aps);
        return sec * aps;
    endfunction

    localparam int unsigned SHORT_STEP = step_of(DEF_SHORT_SEC, DEF_ADDRS_PER_SEC);
    localparam int unsigned LONG_STEP  = step_of(DEF_LONG_SEC, DEF_ADDRS_PER_SEC);

endpackage
`default_nettype wire

// File: rtl/seek_btn_arb.sv
`default_nettype none
// ============================================================================
// Module   : seek_btn_arb
// Purpose  : Priority arbitration of the four seek buttons plus a registered
//            latch of the winning direction/step for the duration of a press.
// Revision : 1.0
// ============================================================================
module seek_btn_arb
    import music_addr_seek_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fwd_short,
    input  logic        back_short,
    input  logic        fwd_long,
    input  logic        back_long,
    input  logic        latch,
    output logic        press,
    output seek_state_t held_state,
    output seek_dir_t   seek_dir,
    output logic        seek_long,
    output logic        owner_level
);

    seek_dir_t w_req_dir;
    logic      w_req_long;
    seek_dir_t r_dir;
    logic      r_long;

    always_comb begin
        press      = fwd_short | back_short | fwd_long | back_long;
        held_state = ST_RUN;
        w_req_dir  = DIR_FWD;
        w_req_long = 1'b0;
        if (fwd_short) begin
            held_state = ST_HELD_FS;
        end else if (back_short) begin
            held_state = ST_HELD_BS;
            w_req_dir  = DIR_BACK;
        end else if (fwd_long) begin
            held_state = ST_HELD_FL;
            w_req_long = 1'b1;
        end else if (back_long) begin
            held_state = ST_HELD_BL;
            w_req_dir  = DIR_BACK;
            w_req_long = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir  <= DIR_FWD;
            r_long <= 1'b0;
        end else if (latch && press) begin
            r_dir  <= w_req_dir;
            r_long <= w_req_long;
        end
    end

    // Only the button that won arbitration can end the hold.
    always_comb begin
        if (r_dir == DIR_FWD) owner_level = r_long ? fwd_long  : fwd_short;
        else                  owner_level = r_long ? back_long : back_short;
    end

    assign seek_dir  = r_dir;
    assign seek_long = r_long;

endmodule
`default_nettype wire

// File: rtl/music_addr_seek.sv
`default_nettype none
// ============================================================================
// Module   : music_addr_seek
// Purpose  : Playback sample-address generator with clamped fwd/back seeks,
//            end-of-track stop/loop and time-display strobes.
//            Optional macro SEEK_REPEAT_EN: auto-repeat seeks while held.
// Revision : 1.0
// ============================================================================
module music_addr_seek
    import music_addr_seek_pkg::*;
#(
    parameter int unsigned AW            = 22,
    parameter int unsigned ADDRS_PER_SEC = DEF_ADDRS_PER_SEC,
    parameter int unsigned SHORT_SEC     = DEF_SHORT_SEC,
    parameter int unsigned LONG_SEC      = DEF_LONG_SEC,
    parameter int unsigned TW            = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 fwd_short,
    input  logic                 back_short,
    input  logic                 fwd_long,
    input  logic                 back_long,
    input  logic                 loop_en,
    input  logic [AW-1:0]        track_end,
    output logic [AW-1:0]        endereco,
    output logic signed [TW-1:0] time_adder,
    output logic                 time_valid,
    output logic                 time_clear,
    output logic                 at_end
);

    localparam int unsigned           c_SHORT_STEP = step_of(SHORT_SEC, ADDRS_PER_SEC);
    localparam int unsigned           c_LONG_STEP  = step_of(LONG_SEC, ADDRS_PER_SEC);
    localparam logic [AW:0]           c_SHORT_W    = (AW+1)'(c_SHORT_STEP);
    localparam logic [AW:0]           c_LONG_W     = (AW+1)'(c_LONG_STEP);
    localparam logic signed [TW-1:0]  c_SHORT_T    = TW'(SHORT_SEC);
    localparam logic signed [TW-1:0]  c_LONG_T     = TW'(LONG_SEC);
    localparam logic signed [TW-1:0]  c_ONE_T      = TW'(1);

    seek_state_t          r_state, w_state_nxt;
    logic [AW-1:0]        r_addr, w_addr_nxt;
    logic signed [TW-1:0] r_adder, w_adder_nxt;
    logic                 r_valid, w_valid_nxt, r_clear, w_clear_nxt, r_at_end, w_at_end_nxt;

    logic        w_press, w_seek_long, w_owner_level, w_latch;
    seek_state_t w_held_state;
    seek_dir_t   w_seek_dir;

    assign w_latch = tick && (r_state == ST_RUN);

    seek_btn_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .fwd_short   (fwd_short),
        .back_short  (back_short),
        .fwd_long    (fwd_long),
        .back_long   (back_long),
        .latch       (w_latch),
        .press       (w_press),
        .held_state  (w_held_state),
        .seek_dir    (w_seek_dir),
        .seek_long   (w_seek_long),
        .owner_level (w_owner_level)
    );

    // Normal playback advance; a track_end below the address counts as reached.
    logic          w_adv_end;
    logic [AW-1:0] w_adv_addr;
    assign w_adv_end  = (r_addr >= track_end);
    assign w_adv_addr = w_adv_end ? (loop_en ? '0 : track_end) : r_addr + AW'(1);

    // Seek arithmetic is one bit wider so the end comparison cannot wrap.
    logic [AW:0]          w_step, w_fwd_sum;
    logic [AW-1:0]        w_back_diff;
    logic signed [TW-1:0] w_sec;
    logic                 w_fwd_ok, w_back_ok;
    assign w_step      = w_seek_long ? c_LONG_W : c_SHORT_W;
    assign w_sec       = w_seek_long ? c_LONG_T : c_SHORT_T;
    assign w_fwd_sum   = {1'b0, r_addr} + w_step;
    assign w_fwd_ok    = (w_fwd_sum <= {1'b0, track_end});
    assign w_back_ok   = ({1'b0, r_addr} >= w_step);
    assign w_back_diff = r_addr - w_step[AW-1:0];

    logic [AW-1:0]        w_ap_addr;
    logic signed [TW-1:0] w_ap_adder;
    logic                 w_ap_valid, w_ap_clear, w_ap_at_end;

    always_comb begin
        w_ap_addr   = r_addr;
        w_ap_adder  = '0;
        w_ap_valid  = 1'b0;
        w_ap_clear  = 1'b0;
        w_ap_at_end = r_at_end;
        if (w_seek_dir == DIR_FWD) begin
            if (w_fwd_ok) begin
                w_ap_addr  = w_fwd_sum[AW-1:0];
                w_ap_adder = w_sec;
                w_ap_valid = 1'b1;
            end else begin
                w_ap_addr  = track_end;
            end
        end else begin
            w_ap_at_end = 1'b0;
            if (w_back_ok) begin
                w_ap_addr  = w_back_diff;
                w_ap_adder = -w_sec;
                w_ap_valid = 1'b1;
            end else begin
                w_ap_addr  = '0;
                w_ap_clear = 1'b1;
            end
        end
    end

`ifdef SEEK_REPEAT_EN
    localparam int unsigned             c_CNT_W    = $clog2(ADDRS_PER_SEC + 1);
    localparam logic [c_CNT_W-1:0]      c_CNT_LAST = c_CNT_W'(ADDRS_PER_SEC - 1);
    logic [c_CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic               r_rep_fired, w_rep_fired_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt  <= '0;
            r_rep_fired <= 1'b0;
        end else begin
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_rep_fired <= w_rep_fired_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_adder_nxt  = r_adder;
        w_valid_nxt  = 1'b0;
        w_clear_nxt  = 1'b0;
        w_at_end_nxt = r_at_end;
`ifdef SEEK_REPEAT_EN
        w_hold_cnt_nxt  = r_hold_cnt;
        w_rep_fired_nxt = r_rep_fired;
`endif
        if (tick) begin
            case (r_state)
                ST_RUN: begin
                    w_addr_nxt   = w_adv_addr;
                    w_clear_nxt  = w_adv_end && loop_en;
                    w_at_end_nxt = w_adv_end && !loop_en;
                    w_adder_nxt  = c_ONE_T;
                    if (w_press) w_state_nxt = w_held_state;
`ifdef SEEK_REPEAT_EN
                    w_hold_cnt_nxt  = '0;
                    w_rep_fired_nxt = 1'b0;
`endif
                end
                ST_HELD_FS, ST_HELD_BS, ST_HELD_FL, ST_HELD_BL: begin
                    w_addr_nxt   = w_adv_addr;
                    w_clear_nxt  = w_adv_end && loop_en;
                    w_at_end_nxt = w_adv_end && !loop_en;
                    if (!w_owner_level) begin
`ifdef SEEK_REPEAT_EN
                        w_state_nxt = r_rep_fired ? ST_RUN : ST_APPLY;
`else
                        w_state_nxt = ST_APPLY;
`endif
                    end
`ifdef SEEK_REPEAT_EN
                    else if (r_hold_cnt == c_CNT_LAST) begin
                        w_addr_nxt      = w_ap_addr;
                        w_adder_nxt     = w_ap_adder;
                        w_valid_nxt     = w_ap_valid;
                        w_clear_nxt     = w_ap_clear;
                        w_at_end_nxt    = w_ap_at_end;
                        w_hold_cnt_nxt  = '0;
                        w_rep_fired_nxt = 1'b1;
                    end else begin
                        w_hold_cnt_nxt  = r_hold_cnt + c_CNT_W'(1);
                    end
`endif
                end
                ST_APPLY: begin
                    w_addr_nxt   = w_ap_addr;
                    w_adder_nxt  = w_ap_adder;
                    w_valid_nxt  = w_ap_valid;
                    w_clear_nxt  = w_ap_clear;
                    w_at_end_nxt = w_ap_at_end;
                    w_state_nxt  = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_addr   <= '0;
            r_adder  <= c_ONE_T;
            r_valid  <= 1'b0;
            r_clear  <= 1'b0;
            r_at_end <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_adder  <= w_adder_nxt;
            r_valid  <= w_valid_nxt;
            r_clear  <= w_clear_nxt;
            r_at_end <= w_at_end_nxt;
        end
    end

    assign endereco   = r_addr;
    assign time_adder = r_adder;
    assign time_valid = r_valid;
    assign time_clear = r_clear;
    assign at_end     = r_at_end;

endmodule
`default_nettype wire

// File: tb/tb_music_addr_seek.sv
`default_nettype none
// ============================================================================
// Module   : tb_music_addr_seek
// Purpose  : Directed self-checking bench for music_addr_seek (default params).
// Revision : 1.0
// ============================================================================
module tb_music_addr_seek;
    import music_addr_seek_pkg::*;

    logic              clk = 1'b0;
    logic              reset, tick, fwd_short, back_short, fwd_long, back_long, loop_en;
    logic [21:0]       track_end, endereco;
    logic signed [8:0] time_adder;
    logic              time_valid, time_clear, at_end;
    int                checks   = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    music_addr_seek dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .fwd_short  (fwd_short),
        .back_short (back_short),
        .fwd_long   (fwd_long),
        .back_long  (back_long),
        .loop_en    (loop_en),
        .track_end  (track_end),
        .endereco   (endereco),
        .time_adder (time_adder),
        .time_valid (time_valid),
        .time_clear (time_clear),
        .at_end     (at_end)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; tick = 1'b1;
        clocks(2);
        checks++; if (endereco !== 22'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", endereco); end
        checks++; if (time_adder !== 9'sd1) begin failures++; $display("FAIL reset_adder got=%0d want=1", time_adder); end
        checks++; if (time_valid !== 1'b0 || time_clear !== 1'b0 || at_end !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b want=000", time_valid, time_clear, at_end); end
        reset = 1'b0;
        clocks(500);
        checks++; if (endereco !== 22'd500) begin failures++; $display("FAIL run_500 got=%0d want=500", endereco); end
        reset = 1'b1;
        clocks(1);
        checks++; if (endereco !== 22'd0 || time_adder !== 9'sd1) begin failures++; $display("FAIL reset_from_500 got=%0d/%0d want=0/1", endereco, time_adder); end
        checks++; if (time_valid !== 1'b0 || time_clear !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b want=00", time_valid, time_clear); end
        reset = 1'b0;
        clocks(50);
        checks++; if (endereco !== 22'd50) begin failures++; $display("FAIL run_50 got=%0d want=50", endereco); end
    endtask

    // From 1000: press (1001), hold (1002), release seen (1003 -> APPLY), apply +30000.
    task automatic test_fwd_short;
        clocks(950);
        checks++; if (endereco !== 22'd1000) begin failures++; $display("FAIL pre_fs got=%0d want=1000", endereco); end
        fwd_short = 1'b1;
        clocks(2);
        checks++; if (endereco !== 22'd1002) begin failures++; $display("FAIL fs_held got=%0d want=1002", endereco); end
        fwd_short = 1'b0;
        clocks(1);
        checks++; if (endereco !== 22'd1003 || time_valid !== 1'b0) begin failures++; $display("FAIL fs_release got=%0d/%b want=1003/0", endereco, time_valid); end
        clocks(1);
        checks++; if (endereco !== 22'd31003) begin failures++; $display("FAIL fs_apply_addr got=%0d want=31003", endereco); end
        checks++; if (time_adder !== 9'sd10 || time_valid !== 1'b1 || time_clear !== 1'b0) begin failures++; $display("FAIL fs_apply_time got=%0d/%b/%b want=10/1/0", time_adder, time_valid, time_clear); end
        clocks(1);
        checks++; if (endereco !== 22'd31004 || time_valid !== 1'b0 || time_adder !== 9'sd1) begin failures++; $display("FAIL fs_after got=%0d/%b/%0d want=31004/0/1", endereco, time_valid, time_adder); end
    endtask

    task automatic test_back_seeks;
        back_short = 1'b1;
        clocks(1);
        back_short = 1'b0;
        clocks(2);
        checks++; if (endereco !== 22'd1006) begin failures++; $display("FAIL bs_apply_addr got=%0d want=1006", endereco); end
        checks++; if (time_adder !== -9'sd10 || time_valid !== 1'b1) begin failures++; $display("FAIL bs_apply_time got=%0d/%b want=-10/1", time_adder, time_valid); end
        clocks(1);
        checks++; if (endereco !== 22'd1007 || time_valid !== 1'b0) begin failures++; $display("FAIL bs_after got=%0d/%b want=1007/0", endereco, time_valid); end
        back_long = 1'b1;
        clocks(1);
        back_long = 1'b0;
        clocks(2);
        checks++; if (endereco !== 22'd0) begin failures++; $display("FAIL bl_floor_addr got=%0d want=0", endereco); end
        checks++; if (time_clear !== 1'b1 || time_valid !== 1'b0) begin failures++; $display("FAIL bl_floor_strobes clear=%b valid=%b want=1/0", time_clear, time_valid); end
        clocks(1);
        checks++; if (endereco !== 22'd1 || time_clear !== 1'b0) begin failures++; $display("FAIL bl_after got=%0d/%b want=1/0", endereco, time_clear); end
    endtask

    task automatic test_end_clamp;
        reset = 1'b1;
        clocks(1);
        reset = 1'b0; track_end = 22'd30002; loop_en = 1'b0;
        fwd_short = 1'b1;
        clocks(1);
        fwd_short = 1'b0;
        clocks(2);
        checks++; if (endereco !== 22'd30002 || time_valid !== 1'b1) begin failures++; $display("FAIL fwd_exact_end got=%0d/%b want=30002/1", endereco, time_valid); end
        clocks(1);
        checks++; if (endereco !== 22'd30002 || at_end !== 1'b1) begin failures++; $display("FAIL stop_at_end got=%0d/%b want=30002/1", endereco, at_end); end
        track_end = 22'd100000;
        clocks(1);
        checks++; if (endereco !== 22'd30003 || at_end !== 1'b0) begin failures++; $display("FAIL end_moved got=%0d/%b want=30003/0", endereco, at_end); end
        fwd_long = 1'b1;
        clocks(1);
        fwd_long = 1'b0;
        clocks(2);
        checks++; if (endereco !== 22'd100000) begin failures++; $display("FAIL fl_clamp_addr got=%0d want=100000", endereco); end
        checks++; if (time_valid !== 1'b0 || time_clear !== 1'b0 || time_adder !== 9'sd0) begin failures++; $display("FAIL fl_clamp_time got=%b/%b/%0d want=0/0/0", time_valid, time_clear, time_adder); end
        clocks(2);
        checks++; if (endereco !== 22'd100000 || at_end !== 1'b1) begin failures++; $display("FAIL hold_at_end got=%0d/%b want=100000/1", endereco, at_end); end
        back_short = 1'b1;
        clocks(1);
        back_short = 1'b0;
        clocks(1);
        checks++; if (endereco !== 22'd100000 || at_end !== 1'b1) begin failures++; $display("FAIL held_at_end got=%0d/%b want=100000/1", endereco, at_end); end
        clocks(1);
        checks++; if (endereco !== 22'd70000 || at_end !== 1'b0 || time_valid !== 1'b1) begin failures++; $display("FAIL resume_back got=%0d/%b/%b want=70000/0/1", endereco, at_end, time_valid); end
        clocks(1);
        checks++; if (endereco !== 22'd70001) begin failures++; $display("FAIL resume_play got=%0d want=70001", endereco); end
    endtask

    task automatic test_loop;
        fwd_long = 1'b1;
        clocks(1);
        fwd_long = 1'b0;
        clocks(2);
        checks++; if (endereco !== 22'd100000 || time_valid !== 1'b0) begin failures++; $display("FAIL loop_clamp got=%0d/%b want=100000/0", endereco, time_valid); end
        loop_en = 1'b1;
        clocks(1);
        checks++; if (endereco !== 22'd0 || time_clear !== 1'b1 || at_end !== 1'b0) begin failures++; $display("FAIL loop_wrap got=%0d/%b/%b want=0/1/0", endereco, time_clear, at_end); end
        clocks(1);
        checks++; if (endereco !== 22'd1 || time_clear !== 1'b0) begin failures++; $display("FAIL loop_after got=%0d/%b want=1/0", endereco, time_clear); end
        loop_en = 1'b0;
    endtask

    task automatic test_tick_gate;
        tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            back_short = (i % 2 == 0);
            clocks(1);
            checks++; if (endereco !== 22'd1 || time_valid !== 1'b0 || time_clear !== 1'b0) begin failures++; $display("FAIL tick_gate[%0d] got=%0d/%b/%b want=1/0/0", i, endereco, time_valid, time_clear); end
        end
        back_short = 1'b0; tick = 1'b1;
        clocks(2);
        checks++; if (endereco !== 22'd3 || time_clear !== 1'b0 || time_valid !== 1'b0) begin failures++; $display("FAIL tick_resume got=%0d/%b/%b want=3/0/0", endereco, time_clear, time_valid); end
    endtask

    task automatic test_reset_mid_seek;
        fwd_long = 1'b1;
        clocks(2);
        checks++; if (endereco !== 22'd5) begin failures++; $display("FAIL fl_held got=%0d want=5", endereco); end
        reset = 1'b1; fwd_long = 1'b0;
        clocks(1);
        checks++; if (endereco !== 22'd0 || time_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0d/%b want=0/0", endereco, time_valid); end
        reset = 1'b0;
        clocks(2);
        checks++; if (endereco !== 22'd2 || time_valid !== 1'b0) begin failures++; $display("FAIL no_seek_after_reset got=%0d/%b want=2/0", endereco, time_valid); end
    endtask

`ifdef SEEK_REPEAT_EN
    task automatic test_repeat;
        int nvalid;
        reset = 1'b1;
        clocks(1);
        reset = 1'b0; nvalid = 0; fwd_short = 1'b1;
        for (int i = 0; i < 6500; i++) begin
            clocks(1);
            if (time_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 2) begin failures++; $display("FAIL repeat_count got=%0d want=2", nvalid); end
        fwd_short = 1'b0; nvalid = 0;
        for (int i = 0; i < 5; i++) begin
            clocks(1);
            if (time_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 0) begin failures++; $display("FAIL repeat_release got=%0d want=0", nvalid); end
    endtask
`endif

    initial begin
        reset = 1'b1; tick = 1'b1; loop_en = 1'b0; track_end = 22'd100000;
        fwd_short = 1'b0; back_short = 1'b0; fwd_long = 1'b0; back_long = 1'b0;
        test_reset();
        test_fwd_short();
        test_back_seeks();
        test_end_clamp();
        test_loop();
        test_tick_gate();
        test_reset_mid_seek();
`ifdef SEEK_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
